// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock constants: the NOKEY code the controller expects,
// keypad matrix positions and the (row,col) to key-code lookup.
package alarm_clock_pkg;

  localparam logic [3:0] NOKEY = 4'd10;

  // Matrix positions are numbered row*3 + col, row 0 = top row
  localparam logic [3:0] KEY_STAR_POS = 4'd9;
  localparam logic [3:0] KEY_ZERO_POS = 4'd10;
  localparam logic [3:0] KEY_HASH_POS = 4'd11;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] pos;
    pos = {2'b00, row} * 4'd3 + {2'b00, col};
    if (pos == KEY_STAR_POS || pos == KEY_HASH_POS)
      return NOKEY;
    else if (pos == KEY_ZERO_POS)
      return 4'd0;
    else if (pos < 4'd9)
      return pos + 4'd1;
    else
      return NOKEY;
  endfunction

  function automatic logic [2:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to RESET_VAL
// so idle pulled-up lines read inactive straight out of reset.
module sync_2ff #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, per-frame single-key decode with
// multi-key rejection, and frame-based debounce feeding a registered key code.
module keypad_scanner
  import alarm_clock_pkg::*;
#(
  parameter int SCAN_DIV        = 8,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [2:0] cols_n,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE_FRAMES - 1);

  logic [3:0]    rows_sync;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [1:0]    col_idx_reg, col_idx_next;
  logic [2:0]    cols_n_reg, cols_n_next;
  logic [1:0]    hit_cnt_reg, hit_cnt_next;
  logic [3:0]    hit_code_reg, hit_code_next;
  logic [3:0]    cand_reg, cand_next;
  logic [SW-1:0] stab_reg, stab_next;
  logic [3:0]    key_reg, key_next;
  logic          key_valid_reg, key_valid_next;

  logic [3:0] row_code [4];
  logic [2:0] col_hits;
  logic [3:0] col_code;
  logic [2:0] hit_sum;
  logic [1:0] merged_cnt;
  logic [3:0] merged_code;
  logic [3:0] raw;
  logic       sample;
  logic       frame_end;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_rows_sync (
    .clock (clock),
    .reset (reset),
    .d     (rows_n),
    .q     (rows_sync)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_row_code
    assign row_code[gi] = key_code(2'(gi), col_idx_reg);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dwell_reg     <= '0;
      col_idx_reg   <= 2'd0;
      cols_n_reg    <= 3'b110;
      hit_cnt_reg   <= 2'd0;
      hit_code_reg  <= NOKEY;
      cand_reg      <= NOKEY;
      stab_reg      <= '0;
      key_reg       <= NOKEY;
      key_valid_reg <= 1'b0;
    end else begin
      dwell_reg     <= dwell_next;
      col_idx_reg   <= col_idx_next;
      cols_n_reg    <= cols_n_next;
      hit_cnt_reg   <= hit_cnt_next;
      hit_code_reg  <= hit_code_next;
      cand_reg      <= cand_next;
      stab_reg      <= stab_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
    end
  end

  always_comb begin
    col_hits = 3'd0;
    col_code = NOKEY;
    for (int r = 0; r < 4; r++) begin
      if (!rows_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = row_code[r];
      end
    end

    // Hit count saturates at 2: anything beyond one key is a reject anyway
    hit_sum     = {1'b0, hit_cnt_reg} + col_hits;
    merged_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    merged_code = (col_hits != 3'd0) ? col_code : hit_code_reg;
    raw         = (merged_cnt == 2'd1) ? merged_code : NOKEY;

    sample    = (dwell_reg == DWELL_LAST);
    frame_end = sample && (col_idx_reg == 2'd2);

    dwell_next     = sample ? '0 : dwell_reg + DW'(1);
    col_idx_next   = col_idx_reg;
    cols_n_next    = cols_n_reg;
    hit_cnt_next   = hit_cnt_reg;
    hit_code_next  = hit_code_reg;
    cand_next      = cand_reg;
    stab_next      = stab_reg;
    key_next       = key_reg;
    key_valid_next = 1'b0;

    if (sample) begin
      col_idx_next = (col_idx_reg == 2'd2) ? 2'd0 : col_idx_reg + 2'd1;
      cols_n_next  = col_drive(col_idx_next);
      if (frame_end) begin
        hit_cnt_next  = 2'd0;
        hit_code_next = NOKEY;
        if (raw != cand_reg) begin
          cand_next = raw;
          stab_next = SW'(1);
        end else begin
          if (stab_reg != STAB_MAX)
            stab_next = stab_reg + SW'(1);
          // Release commits NOKEY through the same path but never pulses key_valid
          if (stab_reg == STAB_MAX && key_reg != cand_reg) begin
            key_next       = cand_reg;
            key_valid_next = (cand_reg != NOKEY);
          end
        end
      end else begin
        hit_cnt_next  = merged_cnt;
        hit_code_next = merged_code;
      end
    end
  end

  assign cols_n    = cols_n_reg;
  assign key       = key_reg;
  assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a behavioural keypad matrix driven
// by a 12-bit press mask, a vector table of frame-aligned steps, and hand sequences.
module tb_keypad_scanner;

  localparam int FRAME = 24;

  localparam logic [11:0] K1   = 12'h001;
  localparam logic [11:0] K2   = 12'h002;
  localparam logic [11:0] K3   = 12'h004;
  localparam logic [11:0] K5   = 12'h010;
  localparam logic [11:0] K7   = 12'h040;
  localparam logic [11:0] K9   = 12'h100;
  localparam logic [11:0] STAR = 12'h200;
  localparam logic [11:0] K0   = 12'h400;
  localparam logic [11:0] HASH = 12'h800;
  localparam logic [11:0] NONE = 12'h000;

  typedef struct {
    logic [11:0] mask;
    int          frames;
    logic [3:0]  exp_key;
    int          exp_pulses;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows_n;
  logic [2:0] cols_n;
  logic [3:0] key;
  logic       key_valid;
  logic [11:0] press_mask = 12'h000;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  vec_t vecs[$];

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_FRAMES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key       (key),
    .key_valid (key_valid)
  );

  always #5 clock = ~clock;

  // A row reads low when any pressed key in it sits on the driven column
  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (press_mask[r*3 + c] && !cols_n[c])
          rows_n[r] = 1'b0;
  end

  always @(posedge clock) begin
    #2;
    if (key_valid === 1'b1)
      pulse_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    int start_pulses;
    logic [2:0] exp_cols;

    vecs.push_back('{NONE, 10, 4'd10, 0});
    vecs.push_back('{K5,    3, 4'd10, 0});
    vecs.push_back('{K5,    1, 4'd5,  1});
    vecs.push_back('{NONE,  3, 4'd5,  0});
    vecs.push_back('{NONE,  1, 4'd10, 0});
    for (int i = 0; i < 3; i++) begin
      vecs.push_back('{K7,   2, 4'd10, 0});
      vecs.push_back('{NONE, 1, 4'd10, 0});
    end
    vecs.push_back('{NONE,    4, 4'd10, 0});
    vecs.push_back('{K3,      4, 4'd3,  1});
    vecs.push_back('{NONE,    4, 4'd10, 0});
    vecs.push_back('{K1 | K9, 4, 4'd10, 0});
    vecs.push_back('{K1,      3, 4'd10, 0});
    vecs.push_back('{K1,      1, 4'd1,  1});
    vecs.push_back('{K1 | K2, 1, 4'd1,  0});
    vecs.push_back('{K2,      3, 4'd1,  0});
    vecs.push_back('{K2,      1, 4'd2,  1});
    vecs.push_back('{STAR,    3, 4'd2,  0});
    vecs.push_back('{STAR,    1, 4'd10, 0});
    vecs.push_back('{HASH,    4, 4'd10, 0});
    vecs.push_back('{K0,      4, 4'd0,  1});

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_key", 32'(key), 32'd10);
    check("reset_valid", 32'(key_valid), 32'd0);
    check("reset_cols", 32'(cols_n), 32'b110);
    reset = 1'b0;

    // Column rotation over the first frame after reset
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clock);
      @(negedge clock);
      case ((k / 8) % 3)
        0:       exp_cols = 3'b110;
        1:       exp_cols = 3'b101;
        default: exp_cols = 3'b011;
      endcase
      check($sformatf("cols_n_cyc%0d", k), 32'(cols_n), 32'(exp_cols));
    end

    foreach (vecs[i]) begin
      press_mask   = vecs[i].mask;
      start_pulses = pulse_cnt;
      repeat (vecs[i].frames * FRAME) @(posedge clock);
      @(negedge clock);
      $display("vec %0d mask=%03h frames=%0d key=%0d pulses=%0d", i, vecs[i].mask,
               vecs[i].frames, key, pulse_cnt - start_pulses);
      check($sformatf("vec%0d_key", i), 32'(key), 32'(vecs[i].exp_key));
      check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - start_pulses), 32'(vecs[i].exp_pulses));
    end

    // '0' has just committed: valid high now, low one cycle later
    check("zero_valid_hi", 32'(key_valid), 32'd1);
    @(posedge clock);
    @(negedge clock);
    check("zero_valid_lo", 32'(key_valid), 32'd0);

    // Reset mid-frame with '0' still held
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    $display("midframe reset key=%0d cols_n=%b", key, cols_n);
    check("mid_reset_key", 32'(key), 32'd10);
    check("mid_reset_cols", 32'(cols_n), 32'b110);
    check("mid_reset_valid", 32'(key_valid), 32'd0);
    reset = 1'b0;
    start_pulses = pulse_cnt;
    repeat (4 * FRAME - 1) @(posedge clock);
    @(negedge clock);
    check("recommit_before", 32'(key), 32'd10);
    @(posedge clock);
    @(negedge clock);
    $display("recommit key=%0d valid=%0d", key, key_valid);
    check("recommit_key", 32'(key), 32'd0);
    check("recommit_valid", 32'(key_valid), 32'd1);
    @(posedge clock);
    @(negedge clock);
    check("recommit_pulses", 32'(pulse_cnt - start_pulses), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
